// File: rtl/imem_loader.sv
// Boot loader: turns a big-endian byte stream into instruction-memory writes and holds the core in reset until done.
// Optional trailing XOR checksum byte is compiled in with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);
    // Handshake: a byte moves only on a rising edge where in_valid && in_ready;
    // in_ready is registered and depends on loader state alone, never on in_valid.
    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [16:0] N_MAX = 17'(1) << ADDR_W;

    state_t            state_q;
    logic [15:0]       count_q;
    logic [23:0]       asm_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W:0]   words_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              in_ready_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    logic              accept;
    logic [15:0]       n_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W:0]   words_d;
    logic [31:0]       addr_d;
    logic [15:0]       words_ext;
    logic [15:0]       words_d_ext;

    always_comb begin
        accept      = in_valid && in_ready_q;
        n_d         = {count_q[15:8], in_data};
        wdata_d     = {asm_q, in_data};
        words_d     = words_q + 1'b1;
        addr_d      = 32'(words_q[ADDR_W-1:0]) << 2;
        words_ext   = 16'(words_q);
        words_d_ext = 16'(words_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_HDR_HI;
            count_q     <= '0;
            asm_q       <= '0;
            byte_cnt_q  <= '0;
            words_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_HDR_HI: begin
                    if (accept) begin
                        count_q[15:8] <= in_data;
                        state_q       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (accept) begin
                        count_q[7:0] <= in_data;
                        if ({1'b0, n_d} > N_MAX) begin
                            state_q    <= S_ERROR;
                            error_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else if (n_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q     <= S_CSUM;
`else
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                            in_ready_q  <= 1'b0;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // Release happens on the edge that closes the final write cycle.
                    if (we_q && words_ext == count_q) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                    end else if (accept) begin
                        asm_q      <= wdata_d[23:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= wdata_d;
                            addr_q  <= addr_d;
                            words_q <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            if (words_d_ext == count_q) begin
                                state_q <= S_CSUM;
                            end
`endif
                        end
                    end
                end
                S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data == xor_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept && (state_q == S_HDR_HI || state_q == S_HDR_LO || state_q == S_DATA)) begin
                xor_q <= xor_q ^ in_data;
            end
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;
    assign dbg_state    = state_q;

    // words_d_ext only steers the checksum-enabled path.
    logic unused_ok;
    assign unused_ok = ^words_d_ext;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes and final status come from a stream-level model.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int MAXW = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic cpu_reset;
  logic done;
  logic error;
  logic [ADDR_W:0] words_loaded;
  logic [2:0] dbg_state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0] stream_q[$];
  int cyc = 0;
  int last_we_cyc;
  int done_cyc;
  int we_count;
  logic done_prev;
  int exp_n;
  logic exp_done;
  logic exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!reset) begin
      check("done_error_excl", 64'(done & error), 64'd0);
      check("cpu_reset_vs_done", 64'(cpu_reset), 64'(!done));
      if (imem_we) begin
        we_count++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_we", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("we_addr", 64'(imem_addr), 64'(e[63:32]));
          check("we_data", 64'(imem_wdata), 64'(e[31:0]));
        end
      end
      if (done && !done_prev) done_cyc = cyc;
      done_prev = done;
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    we_count = 0;
    done_prev = 1'b0;
    done_cyc = -1;
    last_we_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    clear_sb();
  endtask

  // reference model: parses the stream as a whole
  task automatic build_expect();
    int n;
    int idx;
    logic [7:0] x;
    n = {stream_q[0], stream_q[1]};
    exp_n = 0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    if (n > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (2 + 4 * k + 3 < stream_q.size()) begin
        exp_q.push_back({32'(k * 4), stream_q[2+4*k], stream_q[3+4*k], stream_q[4+4*k], stream_q[5+4*k]});
        exp_n++;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    idx = 2 + 4 * n;
    x = 8'h00;
    for (int i = 0; i < idx; i++) x = x ^ stream_q[i];
    if (idx < stream_q.size()) begin
      exp_done = (x == stream_q[idx]);
      exp_err = !exp_done;
    end
`else
    idx = 0;
    x = 8'h00;
    exp_done = (exp_n == n);
`endif
  endtask

  // driver
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int w;
    int gaps;
    w = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
    gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
    repeat (gaps) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream(input int gap_mode);
    for (int i = 0; i < stream_q.size(); i++) send_byte(stream_q[i], gap_mode);
  endtask

  task automatic make_image(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n >> 8));
    stream_q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (stream_q[i]) x = x ^ stream_q[i];
    stream_q.push_back(corrupt ? (x ^ 8'h01) : x);
`else
    x = 8'(corrupt);
`endif
  endtask

  task automatic run_image(input int gap_mode, input bit with_reset);
    int n;
    if (with_reset) do_reset();
    else clear_sb();
    n = {stream_q[0], stream_q[1]};
    build_expect();
    send_stream(gap_mode);
    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("we_count", 64'(we_count), 64'(exp_n));
    check("final_words", 64'(words_loaded), 64'(exp_n));
    check("final_done", 64'(done), 64'(exp_done));
    check("final_error", 64'(error), 64'(exp_err));
    check("final_cpu_reset", 64'(cpu_reset), 64'(!exp_done));
    check("final_in_ready", 64'(in_ready), 64'(!(exp_done || exp_err)));
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (exp_done && n > 0) check("done_latency", 64'(done_cyc - last_we_cyc), 64'd1);
`endif
    // bytes offered in a terminal state must be ignored
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("term_words", 64'(words_loaded), 64'(exp_n));
    check("term_done", 64'(done), 64'(exp_done));
    check("term_error", 64'(error), 64'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    // directed two-word image, back-to-back then with in_valid toggling
    for (int g = 0; g < 2; g++) begin
      stream_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream_q.push_back(8'h00 ^ 8'h02 ^ 8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h05 ^ 8'h8C ^ 8'h09 ^ 8'h00 ^ 8'h04);
`endif
      run_image(g, 1'b1);
    end

    // oversized headers
    stream_q = '{8'h01, 8'h01};
    run_image(0, 1'b1);
    stream_q = '{8'hFF, 8'hFF};
    run_image(2, 1'b1);

    // empty image
    make_image(0, 1'b0);
    run_image(0, 1'b1);

    // reset in the middle of word 1, then a fresh image without another reset pulse
    do_reset();
    stream_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33};
    build_expect();
    send_stream(0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals();
    check("pre_reset_writes", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    make_image(1, 1'b0);
    run_image(0, 1'b0);

    // full-capacity image
    make_image(MAXW, 1'b0);
    run_image(0, 1'b1);

    // random images with random gaps
    for (int t = 0; t < 8; t++) begin
      make_image($urandom_range(1, 9), 1'b0);
      run_image($urandom_range(0, 2), 1'b1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_image(0, 1'b1);
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_image(0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      make_image($urandom_range(1, 5), 1'b1);
      run_image($urandom_range(0, 2), 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into the instruction memory's write port at consecutive word-aligned byte addresses from 0, and holds the core in reset until the image is completely and correctly loaded.

## Interface
- ADDR_W, 8, word-address width; capacity 2^ADDR_W words (default 256)
- clk  in  1  rising-edge clock shared with the core
- reset  in  1  asynchronous, active-high; restarts the loader
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  32  byte address of write (word index × 4, bits [1:0]=0)
- imem_wdata  out  32  instruction word to write
- cpu_reset  out  1  holds core (PC, register file) in reset while high
- done  out  1  image loaded, core released
- error  out  1  load failed; core stays in reset
- words_loaded  out  ADDR_W+1  count of words written so far

## Operation
- Stream format: 2-byte big-endian word count N, then 4·N instruction bytes, MSB first per word. With IMEM_LOADER_CHECKSUM_EN, one checksum byte follows.
- Byte accepted iff in_valid && in_ready at a rising clk edge. in_data is ignored otherwise.
- FSM states:
  - HDR_HI: latch N[15:8], then go to HDR_LO.
  - HDR_LO: latch N[7:0], then branch:
    - N > 2^ADDR_W → ERROR
    - N == 0 → CSUM if enabled, else DONE
    - otherwise → DATA
  - DATA: shift bytes into the assembly register. On the 4th byte of a word, copy the assembled word to imem_wdata, set imem_addr = words_loaded·4, and pulse imem_we in the next cycle. words_loaded increments together with the imem_we pulse.
  - After the write of word N−1 → CSUM if enabled, else DONE.
  - CSUM: compare the accepted byte with the running XOR of every preceding stream byte, header included. Match → DONE; mismatch → ERROR.
  - DONE, ERROR: terminal until reset.
- in_ready = 1 in HDR_HI, HDR_LO, DATA and CSUM, including the imem_we cycle; the next word's bytes may overlap that write. in_ready = 0 in DONE and ERROR.
- Outputs by state:
  - cpu_reset = 1 in every state except DONE.
  - done = 1 only in DONE; error = 1 only in ERROR; done and error are never both 1.
- Address arithmetic: word index is modulo-free; N ≤ 2^ADDR_W guarantees the index never exceeds 2^ADDR_W−1. imem_addr upper bits above ADDR_W+1 are 0.

## Timing
- Reset values (asynchronous):
  - State = HDR_HI.
  - in_ready = 1, cpu_reset = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - done = 0, error = 0, words_loaded = 0, running XOR = 0.
- Write latency: imem_we is high exactly one cycle, in the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are stable during that cycle.
- DONE is entered on the edge that ends the final imem_we cycle. With the checksum enabled, DONE is entered on the edge accepting a correct checksum byte, which is never earlier than one cycle after the final write. cpu_reset falls on the same edge done rises, so the core's first fetch sees memory fully written.
- Back-to-back bytes are accepted every cycle with no bubbles. Gaps in in_valid stall the FSM with no side effects.
- Reset asserted mid-load: immediate return to reset values. Already-written memory words are not cleared. A full image must be resent.
- Bytes presented in DONE or ERROR are not accepted: in_ready = 0 and there is no state change.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CSUM state, running-XOR register and trailing checksum byte are compiled in.
  - A mismatch → ERROR; the core is never released.
- Undefined:
  - No CSUM state or XOR logic.
  - The stream ends after the last data byte; DONE follows the final write directly.

## Test plan
- Load N=2 (00 02, 20 08 00 05, 8C 09 00 04), back-to-back → imem_we pulses writing 0x20080005@0x0 and 0x8C090004@0x4; words_loaded=2; done=1 and cpu_reset=0 one cycle after the second write; in_ready=0 afterwards.
- Same image with in_valid toggling 1/0 every cycle → identical writes and final state; no extra imem_we pulses.
- Header 01 01 (N=257) with ADDR_W=8 → ERROR after the 2nd byte; error=1, cpu_reset=1, no imem_we ever asserted.
- Header 00 00 → DONE immediately (no checksum) or after checksum byte 0x00 (checksum enabled); words_loaded=0.
- Reset asserted after 3 bytes of word 1 → all outputs return to reset values asynchronously; a fresh N=1 image then writes 0x00000000-based address 0x0 correctly.
- With IMEM_LOADER_CHECKSUM_EN, N=1 word 12 34 56 78: checksum 0x09 → done=1; checksum 0x08 → error=1, cpu_reset stays 1.
